tpu_core: RTL and testbench



---
 rtl/tpu_pkg.sv | 14 +
 rtl/tpu_dot4.sv | 22 ++
 rtl/tpu_core.sv | 116 +++++++++++
 tb/tb_tpu_core.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared constants and FSM state encoding for the 4x4 signed matrix-multiply engine.
package tpu_pkg;
  localparam int DIM      = 4;
  localparam int DATA_W   = 8;
  localparam int ACC_W    = 18;
  localparam int FM_DEPTH = 32;
  localparam int WM_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DONE
  } state_t;
endpackage

// File: rtl/tpu_dot4.sv
// Combinational 4-lane signed 8x8 dot product, 18-bit result (cannot overflow).
module tpu_dot4
  import tpu_pkg::*;
(
  input  logic [DIM*DATA_W-1:0]    i_a,
  input  logic [DIM*DATA_W-1:0]    i_b,
  output logic signed [ACC_W-1:0]  o_dot
);

  logic signed [2*DATA_W-1:0] w_prod [DIM];

  always_comb begin
    o_dot  = '0;
    w_prod = '{default: '0};
    for (int k = 0; k < DIM; k++) begin
      w_prod[k] = $signed({{DATA_W{i_a[k*DATA_W+DATA_W-1]}}, i_a[k*DATA_W +: DATA_W]}) *
                  $signed({{DATA_W{i_b[k*DATA_W+DATA_W-1]}}, i_b[k*DATA_W +: DATA_W]});
      o_dot = o_dot + $signed({{(ACC_W-2*DATA_W){w_prod[k][2*DATA_W-1]}}, w_prod[k]});
    end
  end

endmodule

// File: rtl/tpu_core.sv
// 4x4 signed matrix multiply C = A*W, one element per cycle, results stored at feature memory 16..31.
// Build option TPU_CORE_RELU_EN: ReLU activation after saturation (identity when undefined).
module tpu_core
  import tpu_pkg::*;
#(
  parameter int QSHIFT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] port_A,
  input  logic [DATA_W-1:0] port_W,
  input  logic              write_enable_A,
  input  logic              write_enable_W,
  input  logic              startSignal,
  output logic [DATA_W-1:0] port_O,
  output logic              done
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = 18'sd127;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -18'sd128;

  logic [DATA_W-1:0] r_fm [FM_DEPTH];
  logic [DATA_W-1:0] r_wm [WM_DEPTH];
  logic [3:0]        r_ptr_a;
  logic [3:0]        r_ptr_w;
  logic [3:0]        r_idx;
  logic              r_start_q;
  state_t            r_state;
  state_t            w_state_nxt;

  logic                    w_start_edge;
  logic [DIM*DATA_W-1:0]   w_row;
  logic [DIM*DATA_W-1:0]   w_col;
  logic signed [ACC_W-1:0] w_dot;
  logic signed [ACC_W-1:0] w_shift;
  logic [DATA_W-1:0]       w_q;

  assign w_start_edge = startSignal & ~r_start_q;

  // Row r of A and column c of W for the element currently addressed by r_idx.
  always_comb begin
    w_row = '0;
    w_col = '0;
    for (int k = 0; k < DIM; k++) begin
      w_row[k*DATA_W +: DATA_W] = r_fm[{1'b0, r_idx[3:2], 2'(k)}];
      w_col[k*DATA_W +: DATA_W] = r_wm[{2'(k), r_idx[1:0]}];
    end
  end

  tpu_dot4 u_dot4 (
    .i_a   (w_row),
    .i_b   (w_col),
    .o_dot (w_dot)
  );

  assign w_shift = w_dot >>> QSHIFT;

  always_comb begin
    if (w_shift > SAT_MAX) begin
      w_q = 8'h7f;
    end else if (w_shift < SAT_MIN) begin
      w_q = 8'h80;
    end else begin
      w_q = w_shift[DATA_W-1:0];
    end
`ifdef TPU_CORE_RELU_EN
    if (w_q[DATA_W-1]) begin
      w_q = '0;
    end
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start_edge) w_state_nxt = COMPUTE;
      COMPUTE: if (r_idx == 4'd15) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_ptr_a   <= '0;
      r_ptr_w   <= '0;
      r_start_q <= 1'b0;
      port_O    <= '0;
      done      <= 1'b0;
      for (int i = 0; i < FM_DEPTH; i++) r_fm[i] <= '0;
      for (int i = 0; i < WM_DEPTH; i++) r_wm[i] <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_start_q <= startSignal;
      done      <= (r_state == DONE);
      if (r_state == IDLE) begin
        r_idx <= '0;
        if (write_enable_A) begin
          r_fm[{1'b0, r_ptr_a}] <= port_A;
          r_ptr_a               <= r_ptr_a + 4'd1;
        end
        if (write_enable_W) begin
          r_wm[r_ptr_w] <= port_W;
          r_ptr_w       <= r_ptr_w + 4'd1;
        end
      end else if (r_state == COMPUTE) begin
        r_fm[{1'b1, r_idx}] <= w_q;
        port_O              <= w_q;
        r_idx               <= r_idx + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_tpu_core.sv
// Self-checking bench for tpu_core: hand sequences, saturation table and random matrices vs a reference model.
module tb_tpu_core;

  localparam int QSHIFT = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] port_A;
  logic [7:0] port_W;
  logic       write_enable_A;
  logic       write_enable_W;
  logic       startSignal;
  logic [7:0] port_O;
  logic       done;

  tpu_core #(.QSHIFT(QSHIFT)) dut (
    .clk            (clk),
    .rst            (rst),
    .port_A         (port_A),
    .port_W         (port_W),
    .write_enable_A (write_enable_A),
    .write_enable_W (write_enable_W),
    .startSignal    (startSignal),
    .port_O         (port_O),
    .done           (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state: A and W matrices as plain integers plus the load pointers.
  int ma [16];
  int mw [16];
  int pa = 0;
  int pw = 0;
  int got [16];

  typedef struct {
    int a;
    int w;
    int exp_c;
  } sat_vec_t;

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
    end
  endtask

  function automatic int quant(input int s);
    int v;
    v = s >>> QSHIFT;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
`ifdef TPU_CORE_RELU_EN
    if (v < 0) v = 0;
`endif
    return v;
  endfunction

  function automatic int model_c(input int idx);
    int s;
    s = 0;
    for (int k = 0; k < 4; k++) s += ma[(idx / 4) * 4 + k] * mw[k * 4 + (idx % 4)];
    return quant(s);
  endfunction

  function automatic int sx8(input int v);
    logic [7:0] t;
    t = 8'(v);
    return int'($signed(t));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input bit ea, input int w, input bit ew);
    port_A = 8'(a);
    port_W = 8'(w);
    write_enable_A = ea;
    write_enable_W = ew;
    tick();
    write_enable_A = 1'b0;
    write_enable_W = 1'b0;
    if (ea) begin ma[pa] = sx8(a); pa = (pa + 1) % 16; end
    if (ew) begin mw[pw] = sx8(w); pw = (pw + 1) % 16; end
  endtask

  task automatic load_all(input int av [16], input int wv [16]);
    for (int i = 0; i < 16; i++) wr(av[i], 1'b1, wv[i], 1'b1);
  endtask

  // One full multiply from a fresh start edge; results captured into got[].
  task automatic run_compute(input string tag, input bit hold, input bit glitch, input bit junk);
    int exp_c [16];
    int dones;
    dones = 0;
    for (int i = 0; i < 16; i++) exp_c[i] = model_c(i);
    startSignal = 1'b1;
    tick();
    chk({tag, " done_at_E0"}, int'(done), 0);
    if (!hold) startSignal = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (junk) begin
        write_enable_A = 1'b1;
        write_enable_W = 1'b1;
        port_A = 8'($urandom_range(0, 255));
        port_W = 8'($urandom_range(0, 255));
      end
      if (glitch && k == 3) startSignal = 1'b0;
      if (glitch && k == 5) startSignal = 1'b1;
      tick();
      got[k] = int'($signed(port_O));
      chk($sformatf("%s C%0d", tag, k), got[k], exp_c[k]);
      if (done) dones++;
    end
    write_enable_A = 1'b0;
    write_enable_W = 1'b0;
    chk({tag, " done_early"}, dones, 0);
    tick();
    chk({tag, " done_pulse"}, int'(done), 1);
    tick();
    chk({tag, " done_fall"}, int'(done), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) dones++;
    end
    chk({tag, " no_retrigger"}, dones, 0);
    startSignal = 1'b0;
    tick();
  endtask

  initial begin
    int av [16];
    int wv [16];
    int ref_row [4];
    int dones;
    sat_vec_t tbl [7];

`ifdef TPU_CORE_RELU_EN
    tbl = '{'{127, 127, 127}, '{-128, 127, 0}, '{1, 1, 4}, '{-1, 3, 0},
            '{10, 10, 127}, '{-2, 5, 0}, '{-128, -128, 127}};
`else
    tbl = '{'{127, 127, 127}, '{-128, 127, -128}, '{1, 1, 4}, '{-1, 3, -12},
            '{10, 10, 127}, '{-2, 5, -40}, '{-128, -128, 127}};
`endif
    ref_row = '{40, 27, 14, 8};

    rst = 1'b1;
    port_A = '0;
    port_W = '0;
    write_enable_A = 1'b0;
    write_enable_W = 1'b0;
    startSignal = 1'b0;
    for (int i = 0; i < 16; i++) begin ma[i] = 0; mw[i] = 0; end
    #3;
    chk("reset port_O", int'(port_O), 0);
    chk("reset done", int'(done), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reference multiply with known answer.
    for (int i = 0; i < 16; i++) av[i] = (i % 4) + 1;
    wv = '{4, 0, 2, 1, 4, 3, 2, 0, 4, 3, 0, 1, 4, 3, 2, 1};
    load_all(av, wv);
    run_compute("refmul", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) chk($sformatf("refmul known C%0d", i), got[i], ref_row[i % 4]);

    // Identity A: C reproduces W in row-major order.
    for (int i = 0; i < 16; i++) begin
      av[i] = (i % 5 == 0) ? 1 : 0;
      wv[i] = int'($urandom_range(0, 255));
    end
    load_all(av, wv);
    run_compute("ident", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) chk($sformatf("ident W%0d", i), got[i], quant(sx8(wv[i])));

    // Saturation / sign table: uniform A and W.
    for (int t = 0; t < 7; t++) begin
      for (int i = 0; i < 16; i++) begin av[i] = tbl[t].a; wv[i] = tbl[t].w; end
      load_all(av, wv);
      run_compute($sformatf("sat%0d", t), 1'b0, 1'b0, 1'b0);
      chk($sformatf("sat%0d table", t), got[15], tbl[t].exp_c);
    end

    // Pointer wrap: W = identity, 17 A writes with the last landing on entry 0.
    for (int i = 0; i < 16; i++) wr(0, 1'b0, (i % 5 == 0) ? 1 : 0, 1'b1);
    for (int i = 0; i < 16; i++) wr(i + 20, 1'b1, 0, 1'b0);
    wr(9, 1'b1, 0, 1'b0);
    run_compute("wrap", 1'b0, 1'b0, 1'b1);
    chk("wrap entry0", got[0], 9);
    chk("wrap entry1", got[1], 21);
    run_compute("after_junk", 1'b0, 1'b1, 1'b0);
    chk("after_junk entry0", got[0], 9);
    // Pointers must not have moved during compute: this load starts at A entry 1.
    for (int i = 0; i < 16; i++) wr(i - 8, 1'b1, 0, 1'b0);
    run_compute("ptr_hold", 1'b0, 1'b0, 1'b0);
    chk("ptr_hold entry0", got[0], 7);

    // Start held high for 40 cycles: exactly one compute.
    for (int i = 0; i < 16; i++) begin
      av[i] = int'($urandom_range(0, 255));
      wv[i] = int'($urandom_range(0, 255));
    end
    load_all(av, wv);
    dones = 0;
    startSignal = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) dones++;
    end
    startSignal = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) dones++;
    end
    chk("held_start done_count", dones, 1);
    chk("held_start last", int'($signed(port_O)), model_c(15));

    // Reset mid-compute at result k=5.
    startSignal = 1'b1;
    tick();
    startSignal = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("midrst C5", int'($signed(port_O)), model_c(5));
    rst = 1'b1;
    #1;
    chk("midrst port_O", int'(port_O), 0);
    chk("midrst done", int'(done), 0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin ma[i] = 0; mw[i] = 0; end
    pa = 0;
    pw = 0;
    tick();
    run_compute("cleared", 1'b0, 1'b0, 1'b0);
    load_all(av, wv);
    run_compute("reload", 1'b1, 1'b0, 1'b0);

    // Random matrices against the model.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) begin
        av[i] = int'($urandom_range(0, 255));
        wv[i] = int'($urandom_range(0, 255));
      end
      load_all(av, wv);
      run_compute($sformatf("rand%0d", r), r[0], r[1], r[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
